sram_like_bridge: RTL and testbench
===================================

// Module: sram_like_bridge
// PURPOSE
//  Single-channel bridge from the CPU's one-cycle SRAM port (en/wen/addr/wdata/rdata) to an
//  SRAM-like handshake bus (req/addr_ok/data_ok) with variable latency. It stalls the pipeline
//  until data returns, then holds read data until the pipeline releases its global stall.
//  Instantiated twice in the CPU top: once for the instruction port, once for the data port.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; multiple of 8
//  STRB_W       DATA_W/8  byte-enable width (derived; do not override)
//  RDATA_RST    0   reset value of held read data
// PORTS
//  clk          in   1       clock
//  resetn       in   1       synchronous reset, active-low
//  cpu_en       in   1       CPU requests access this cycle
//  cpu_wen      in   STRB_W  byte write enables; all-zero = read
//  cpu_addr     in   ADDR_W  byte address
//  cpu_wdata    in   DATA_W  write data
//  cpu_hold     in   1       pipeline-wide stall (OR of all stall sources)
//  cpu_rdata    out  DATA_W  read data, valid in DONE
//  cpu_stall    out  1       this bridge requests pipeline stall
//  req          out  1       bus request
//  wr           out  1       1 = write
//  size         out  2       0 = byte, 1 = half, 2 = word
//  addr         out  ADDR_W  bus address
//  wdata        out  DATA_W  bus write data
//  addr_ok      in   1       request accepted (valid with req)
//  data_ok      in   1       read data returned / write done
//  rdata        in   DATA_W  bus read data (valid with data_ok)
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT, DONE. Reset (resetn=0 at posedge) -> IDLE; req=0, wr=0,
//    size=0, addr=0, wdata=0, cpu_rdata=RDATA_RST. Reset mid-transaction aborts to IDLE.
//  - IDLE: cpu_en=1 -> latch wr=|cpu_wen, addr, wdata, size; go to REQ.
//  - REQ: req=1 with latched fields stable; addr_ok=1 -> WAIT. data_ok is ignored in REQ.
//    The bus never asserts data_ok in the same cycle as addr_ok.
//  - WAIT: req=0; data_ok=1 -> latch rdata (reads only; writes keep the old value) -> DONE.
//  - DONE: cpu_rdata is held. cpu_hold=0 -> IDLE; cpu_hold=1 -> remain in DONE.
//  - cpu_stall = (state==IDLE & cpu_en) | state==REQ | state==WAIT. It is combinational and
//    0 in DONE.
//  - Minimum latency with addr_ok in the first REQ cycle and data_ok one cycle later:
//    cpu_en in cycle 0, req in cycle 1, data_ok in cycle 2, DONE in cycle 3.
//  - Once issued, a transaction cannot be cancelled. cpu_en/cpu_addr changes in REQ or WAIT
//    are ignored.
//  - data_ok arriving in IDLE or DONE (stale, e.g. after reset) is ignored.
//  - size decode from cpu_wen:
//    - one bit set -> 0
//    - 2 contiguous aligned bits -> 1
//    - all bits set, or all-zero (read) -> 2
//    - any other pattern -> 2
//  - addr is passed unmodified; the CPU guarantees alignment.
// CONFIGURATION
//  BRIDGE_PERF_CNT_EN defined:
//    - adds outputs perf_xfer_cnt[31:0] (+1 on each WAIT->DONE) and perf_stall_cnt[31:0]
//      (+1 each cycle cpu_stall=1).
//    - both counters reset to 0 and wrap at 2^32.
//  BRIDGE_PERF_CNT_EN undefined: these ports and counters are absent; behaviour is otherwise
//  identical.
// STRUCTURE
//  - Package mycpu_bridge_pkg: state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3)
//    and SIZE_BYTE/SIZE_HALF/SIZE_WORD constants.
//  - One sub-module, bridge_size_dec: combinational cpu_wen -> {wr, size}.
//  - FSM, latches and the optional counters live in the top.
// TESTING
//  1. Read, addr_ok in the first REQ cycle, data_ok 1 cycle later, rdata=32'hDEADBEEF,
//     cpu_hold=0 -> req high 1 cycle, cpu_stall high cycles 0-2, cpu_rdata=DEADBEEF in
//     cycle 3, IDLE in cycle 4.
//  2. Write with cpu_wen=4'b0011, addr=32'h100, addr_ok delayed 3 cycles -> wr=1, size=1,
//     addr/wdata stable while req=1, single WAIT->DONE.
//  3. In DONE with cpu_hold=1 for 5 cycles while bus rdata changes -> cpu_rdata stays at
//     the latched value and cpu_stall=0 throughout.
//  4. resetn=0 during WAIT, then data_ok pulses in IDLE -> no state change, cpu_rdata=0,
//     no stall.
//  5. cpu_wen=4'b0100 -> size=0; cpu_wen=4'b1100 -> size=1; cpu_wen=4'b1111 -> size=2;
//     cpu_wen=4'b0000 -> wr=0, size=2.
//  6. BRIDGE_PERF_CNT_EN defined, 3 back-to-back reads of 4 stall cycles each ->
//     perf_xfer_cnt=3, perf_stall_cnt=12.

Source files
------------

// File: rtl/mycpu_bridge_pkg.sv
// Shared types and constants for the SRAM-like bus bridge.
package mycpu_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : mycpu_bridge_pkg

// File: rtl/bridge_size_dec.sv
// Byte-enable decoder: turns the CPU's byte write enables into the bus
// write flag and transfer size. Reads (no enables set) are always full width.
module bridge_size_dec
    import mycpu_bridge_pkg::*;
#(
    parameter int STRB_W = 4
) (
    input  logic [STRB_W-1:0] wen_i,
    output logic              wr_o,
    output logic [1:0]        size_o
);

    int unsigned set_cnt;
    logic        half_hit;

    // Count enabled lanes and look for exactly one aligned lane pair.
    always_comb begin
        set_cnt  = 0;
        half_hit = 1'b0;
        for (int i = 0; i < STRB_W; i++) begin
            set_cnt = set_cnt + {31'd0, wen_i[i]};
        end
        for (int k = 0; k < STRB_W / 2; k++) begin
            if ((set_cnt == 2) && wen_i[2*k] && wen_i[2*k+1]) begin
                half_hit = 1'b1;
            end
        end
        wr_o = |wen_i;
        if (set_cnt == 1) begin
            size_o = SIZE_BYTE;
        end else if (half_hit) begin
            size_o = SIZE_HALF;
        end else begin
            size_o = SIZE_WORD;
        end
    end

endmodule : bridge_size_dec

// File: rtl/sram_like_bridge.sv
// Bridge from the CPU's single-cycle SRAM port to an SRAM-like req/addr_ok/
// data_ok bus. Stalls the pipeline while a transfer is in flight and holds
// the returned read data until the global stall drops.
// Optional feature: define BRIDGE_PERF_CNT_EN to add transfer and stall
// performance counters (perf_xfer_cnt, perf_stall_cnt).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transfer; a cpu_en latches the request fields
// ST_REQ  | req driven with latched fields until addr_ok
// ST_WAIT | request accepted, waiting for data_ok
// ST_DONE | result ready, cpu_rdata held until cpu_hold drops
module sram_like_bridge
    import mycpu_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    localparam int               STRB_W    = DATA_W / 8,
    parameter logic [DATA_W-1:0] RDATA_RST = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [STRB_W-1:0] cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
`ifdef BRIDGE_PERF_CNT_EN
    output logic [31:0]       perf_xfer_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    bridge_state_e     state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              dec_wr;
    logic [1:0]        dec_size;

    bridge_size_dec #(
        .STRB_W (STRB_W)
    ) u_size_dec (
        .wen_i  (cpu_wen),
        .wr_o   (dec_wr),
        .size_o (dec_size)
    );

    // Next-state and field capture; latched fields only move in IDLE so the
    // bus sees them stable for the whole request.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_en) begin
                    wr_d    = dec_wr;
                    size_d  = dec_size;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (data_ok) begin
                    if (!wr_q) begin
                        rdata_d = rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!cpu_hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-field registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= RDATA_RST;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall is combinational so the pipeline freezes in the same cycle as cpu_en.
    always_comb begin
        req       = (state_q == ST_REQ);
        cpu_stall = ((state_q == ST_IDLE) && cpu_en) ||
                    (state_q == ST_REQ) || (state_q == ST_WAIT);
        wr        = wr_q;
        size      = size_q;
        addr      = addr_q;
        wdata     = wdata_q;
        cpu_rdata = rdata_q;
    end

`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0] perf_xfer_q;
    logic [31:0] perf_stall_q;

    // Completed transfers and stalled cycles; both wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_xfer_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == ST_WAIT) && data_ok) begin
                perf_xfer_q <= perf_xfer_q + 32'd1;
            end
            if (cpu_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_xfer_cnt  = perf_xfer_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule : sram_like_bridge

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: transaction-level reference model compared on
// every cycle, directed scenarios with literal expectations, then random
// traffic. Define BRIDGE_PERF_CNT_EN to also cover the performance counters.
module tb_sram_like_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_en = 1'b0;
    logic [SW-1:0] cpu_wen = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_hold = 1'b0;
    logic          addr_ok = 1'b0;
    logic          data_ok = 1'b0;
    logic [DW-1:0] rdata = '0;

    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
`ifdef BRIDGE_PERF_CNT_EN
    logic [31:0]   perf_xfer_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    sram_like_bridge #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RDATA_RST ('0)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cpu_en         (cpu_en),
        .cpu_wen        (cpu_wen),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_hold       (cpu_hold),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .req            (req),
        .wr             (wr),
        .size           (size),
        .addr           (addr),
        .wdata          (wdata),
`ifdef BRIDGE_PERF_CNT_EN
        .perf_xfer_cnt  (perf_xfer_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .addr_ok        (addr_ok),
        .data_ok        (data_ok),
        .rdata          (rdata)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transfer is "issued" (waiting for acceptance), then "accepted"
    // (waiting for data), then "held" (result presented until hold drops).
    bit            m_issued = 0;
    bit            m_accepted = 0;
    bit            m_held = 0;
    logic          m_wr = 0;
    logic [1:0]    m_size = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_wdata = 0;
    logic [DW-1:0] m_rdata = 0;
    logic [31:0]   m_xfer = 0;
    logic [31:0]   m_stall = 0;

    function automatic logic [1:0] exp_size(input logic [SW-1:0] w);
        logic [SW-1:0] pair;
        pair = SW'(3);
        if (w == '0) return 2'd2;
        if ($countones(w) == 1) return 2'd0;
        for (int i = 0; i < SW; i += 2) begin
            if (w == (pair << i)) return 2'd1;
        end
        return 2'd2;
    endfunction

    function automatic bit exp_stall();
        bit busy;
        busy = m_issued || m_accepted || m_held;
        return m_issued || m_accepted || (!busy && cpu_en);
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_issued = 0; m_accepted = 0; m_held = 0;
            m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
            m_xfer = 0; m_stall = 0;
        end else begin
            if (exp_stall()) m_stall = m_stall + 1;
            if (m_held) begin
                if (!cpu_hold) m_held = 0;
            end else if (m_accepted) begin
                if (data_ok) begin
                    if (!m_wr) m_rdata = rdata;
                    m_accepted = 0;
                    m_held = 1;
                    m_xfer = m_xfer + 1;
                end
            end else if (m_issued) begin
                if (addr_ok) begin
                    m_issued = 0;
                    m_accepted = 1;
                end
            end else if (cpu_en) begin
                m_wr = |cpu_wen;
                m_size = exp_size(cpu_wen);
                m_addr = cpu_addr;
                m_wdata = cpu_wdata;
                m_issued = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("req", req, m_issued);
            chk("cpu_stall", cpu_stall, exp_stall());
            chk("wr", wr, m_wr);
            chk("size", size, m_size);
            chk("addr", addr, m_addr);
            chk("wdata", wdata, m_wdata);
            chk("cpu_rdata", cpu_rdata, m_rdata);
`ifdef BRIDGE_PERF_CNT_EN
            chk("perf_xfer_cnt", perf_xfer_cnt, m_xfer);
            chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer starting in idle; returns in idle with cpu_en=0.
    task automatic run_txn(input logic [SW-1:0] wen, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int a_dly, input int d_dly,
                           input logic [DW-1:0] rd, input int hold_cyc);
        cpu_en = 1; cpu_wen = wen; cpu_addr = a; cpu_wdata = wd;
        cpu_hold = 0; addr_ok = 0; data_ok = 0;
        step();
        cpu_en = $urandom_range(0, 1);
        cpu_addr = $urandom;
        repeat (a_dly) step();
        addr_ok = 1;
        step();
        addr_ok = 0;
        repeat (d_dly) step();
        data_ok = 1; rdata = rd;
        step();
        data_ok = 0; cpu_en = 0;
        for (int h = 0; h < hold_cyc; h++) begin
            cpu_hold = 1;
            rdata = $urandom;
            @(negedge clk);
            chk("hold_rdata", cpu_rdata, (wen == '0) ? rd : m_rdata);
            chk("hold_stall", cpu_stall, 1'b0);
            step();
        end
        cpu_hold = 0;
        step();
    endtask

    logic [SW-1:0] t5_wen  [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b0000};
    logic [1:0]    t5_size [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic          t5_wr   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [SW-1:0] rnd_wen [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                   4'b1100, 4'b1111, 4'b0110, 4'b0101, 4'b1110, 4'b1001};

    initial begin
        logic [31:0] xfer_before;

        resetn = 0;
        repeat (3) step();
        resetn = 1;
        chk_on = 1;

        // Reset values
        @(negedge clk);
        chk("rst_req", req, 1'b0);
        chk("rst_wr", wr, 1'b0);
        chk("rst_size", size, 2'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_stall", cpu_stall, 1'b0);
        step();

        // Test 1: minimum-latency read
        cpu_en = 1; cpu_wen = 4'b0000; cpu_addr = 32'h40;
        @(negedge clk);
        chk("t1_c0_stall", cpu_stall, 1'b1);
        chk("t1_c0_req", req, 1'b0);
        step();
        cpu_en = 0; addr_ok = 1;
        @(negedge clk);
        chk("t1_c1_req", req, 1'b1);
        chk("t1_c1_stall", cpu_stall, 1'b1);
        chk("t1_c1_addr", addr, 32'h40);
        step();
        addr_ok = 0; data_ok = 1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_c2_req", req, 1'b0);
        chk("t1_c2_stall", cpu_stall, 1'b1);
        step();
        data_ok = 0; rdata = 32'h0;
        @(negedge clk);
        chk("t1_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_c3_stall", cpu_stall, 1'b0);
        step();
        cpu_en = 1;
        @(negedge clk);
        chk("t1_c4_idle_stall", cpu_stall, 1'b1);
        chk("t1_c4_req", req, 1'b0);
        step();
        cpu_en = 0; addr_ok = 1;
        step();
        addr_ok = 0; data_ok = 1; rdata = 32'h0BADF00D;
        step();
        data_ok = 0;
        step();

        // Test 2: half-word write with delayed acceptance
        xfer_before = m_xfer;
        run_txn(4'b0011, 32'h100, 32'h12345678, 3, 0, 32'h55555555, 0);
        @(negedge clk);
        chk("t2_wr", wr, 1'b1);
        chk("t2_size", size, 2'd1);
        chk("t2_addr", addr, 32'h100);
        chk("t2_wdata", wdata, 32'h12345678);
        chk("t2_rdata_kept", cpu_rdata, 32'h0BADF00D);
        chk("t2_one_xfer", m_xfer - xfer_before, 32'd1);
        step();

        // Test 3: read result held through 5 hold cycles
        run_txn(4'b0000, 32'h200, 32'h0, 1, 2, 32'hCAFE0123, 5);
        @(negedge clk);
        chk("t3_rdata", cpu_rdata, 32'hCAFE0123);
        step();

        // Test 4: reset during WAIT, then stale data_ok pulses
        cpu_en = 1; cpu_wen = 4'b0000; cpu_addr = 32'h300;
        step();
        cpu_en = 0; addr_ok = 1;
        step();
        addr_ok = 0;
        step();
        resetn = 0;
        step();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            data_ok = 1; rdata = $urandom;
            @(negedge clk);
            chk("t4_rdata", cpu_rdata, 32'h0);
            chk("t4_stall", cpu_stall, 1'b0);
            chk("t4_req", req, 1'b0);
            step();
        end
        data_ok = 0;

        // Test 5: size decode
        for (int i = 0; i < 4; i++) begin
            run_txn(t5_wen[i], 32'h400 + 32'(4 * i), $urandom, 0, 0, $urandom, 0);
            @(negedge clk);
            chk("t5_size", size, t5_size[i]);
            chk("t5_wr", wr, t5_wr[i]);
            step();
        end

`ifdef BRIDGE_PERF_CNT_EN
        // Test 6: three back-to-back 4-stall-cycle reads after reset
        cpu_en = 0;
        resetn = 0;
        step();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            run_txn(4'b0000, 32'h500, 32'h0, 0, 1, $urandom, 0);
        end
        @(negedge clk);
        chk("t6_xfer", perf_xfer_cnt, 32'd3);
        chk("t6_stall", perf_stall_cnt, 32'd12);
        step();
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            resetn    = ($urandom_range(0, 199) != 0);
            cpu_en    = $urandom_range(0, 1);
            cpu_wen   = rnd_wen[$urandom_range(0, 11)];
            cpu_addr  = $urandom & 32'hFFFF_FFFC;
            cpu_wdata = $urandom;
            cpu_hold  = ($urandom_range(0, 2) == 0);
            addr_ok   = ($urandom_range(0, 2) == 0);
            data_ok   = addr_ok ? 1'b0 : ($urandom_range(0, 2) == 0);
            rdata     = $urandom;
            step();
        end
        resetn = 1; cpu_en = 0; addr_ok = 0; data_ok = 0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_sram_like_bridge
